// File: rtl/foc_loop_sequencer.sv
// FOC loop sequencer: snapshots sensor samples on each PWM tick, launches the FOC core,
// waits for completion or timeout, and slots PID coefficient writes between iterations.
module foc_loop_sequencer #(
  parameter int D_WIDTH        = 19,
  parameter int VALID_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int OVR_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 trig_in,
  input  logic [D_WIDTH-1:0]   angle_s,
  input  logic [D_WIDTH-1:0]   currA_s,
  input  logic [D_WIDTH-1:0]   currB_s,
  input  logic [D_WIDTH-1:0]   currT_s,
  input  logic                 cfg_wen,
  input  logic                 cfg_sel,
  input  logic [D_WIDTH-1:0]   cfg_addr,
  input  logic [D_WIDTH-1:0]   cfg_data,
  output logic                 cfg_ready,
  output logic [D_WIDTH-1:0]   angle_out,
  output logic [D_WIDTH-1:0]   currA_out,
  output logic [D_WIDTH-1:0]   currB_out,
  output logic [D_WIDTH-1:0]   currT_out,
  output logic                 core_valid,
  input  logic                 core_ready,
  output logic                 pid_d_wen,
  output logic                 pid_q_wen,
  output logic [D_WIDTH-1:0]   pid_d_addr,
  output logic [D_WIDTH-1:0]   pid_q_addr,
  output logic [D_WIDTH-1:0]   pid_d_data,
  output logic [D_WIDTH-1:0]   pid_q_data,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [OVR_WIDTH-1:0] overrun_cnt
);

  localparam int T_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CFG, LAUNCH, WAIT} state_t;

  state_t             state;
  logic [D_WIDTH-1:0] sh_angle, sh_a, sh_b, sh_t;
  logic               pending;
  logic               full;
  logic               h_sel;
  logic [D_WIDTH-1:0] h_addr, h_data;
  logic [T_W-1:0]     tcnt;
  logic               ready_q;
  logic               launch_edge;
  logic               rise;

  // The launch edge consumes the pending snapshot, so a trigger on that edge is not an overrun.
  assign launch_edge = (state == IDLE) && pending;
  assign rise        = core_ready & ~ready_q;
  assign busy        = (state != IDLE);
  assign cfg_ready   = ~full;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state       <= IDLE;
      sh_angle    <= '0;
      sh_a        <= '0;
      sh_b        <= '0;
      sh_t        <= '0;
      pending     <= 1'b0;
      full        <= 1'b0;
      h_sel       <= 1'b0;
      h_addr      <= '0;
      h_data      <= '0;
      tcnt        <= '0;
      ready_q     <= 1'b0;
      angle_out   <= '0;
      currA_out   <= '0;
      currB_out   <= '0;
      currT_out   <= '0;
      core_valid  <= 1'b0;
      pid_d_wen   <= 1'b0;
      pid_q_wen   <= 1'b0;
      pid_d_addr  <= '0;
      pid_q_addr  <= '0;
      pid_d_data  <= '0;
      pid_q_data  <= '0;
      timeout_err <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      ready_q   <= core_ready;
      pid_d_wen <= 1'b0;
      pid_q_wen <= 1'b0;

      if (trig_in) begin
        sh_angle <= angle_s;
        sh_a     <= currA_s;
        sh_b     <= currB_s;
        sh_t     <= currT_s;
        pending  <= 1'b1;
        if (pending && !launch_edge && (overrun_cnt != '1))
          overrun_cnt <= overrun_cnt + OVR_WIDTH'(1);
      end else if (launch_edge) begin
        pending <= 1'b0;
      end

      if (cfg_wen && !full) begin
        h_sel  <= cfg_sel;
        h_addr <= cfg_addr;
        h_data <= cfg_data;
        full   <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pending) begin
            state      <= LAUNCH;
            angle_out  <= sh_angle;
            currA_out  <= sh_a;
            currB_out  <= sh_b;
            currT_out  <= sh_t;
            core_valid <= 1'b1;
            tcnt       <= '0;
          end else if (full) begin
            state <= CFG;
            full  <= 1'b0;
            if (h_sel) begin
              pid_q_wen  <= 1'b1;
              pid_q_addr <= h_addr;
              pid_q_data <= h_data;
            end else begin
              pid_d_wen  <= 1'b1;
              pid_d_addr <= h_addr;
              pid_d_data <= h_data;
            end
          end
        end
        CFG: state <= IDLE;
        LAUNCH: begin
          tcnt <= tcnt + T_W'(1);
          if (tcnt == T_W'(VALID_CYCLES - 1)) begin
            core_valid <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          tcnt <= tcnt + T_W'(1);
          if (rise) begin
            state <= IDLE;
          end else if (tcnt == T_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_foc_loop_sequencer.sv
// Directed bench for foc_loop_sequencer: a vector table for launch/cfg basics plus
// hand-written sequences for overlap, overrun, timeout and mid-iteration reset.
module tb_foc_loop_sequencer;

  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rstb;
  logic          trig_in;
  logic [DW-1:0] angle_s, currA_s, currB_s, currT_s;
  logic          cfg_wen, cfg_sel;
  logic [DW-1:0] cfg_addr, cfg_data;
  logic          cfg_ready;
  logic [DW-1:0] angle_out, currA_out, currB_out, currT_out;
  logic          core_valid, core_ready;
  logic          pid_d_wen, pid_q_wen;
  logic [DW-1:0] pid_d_addr, pid_q_addr, pid_d_data, pid_q_data;
  logic          busy, timeout_err;
  logic [7:0]    overrun_cnt;

  int vec_count = 0;
  int miscompares = 0;

  foc_loop_sequencer #(
    .D_WIDTH(DW), .VALID_CYCLES(4), .TIMEOUT_CYCLES(256), .OVR_WIDTH(8)
  ) dut (
    .clk(clk), .rstb(rstb), .trig_in(trig_in),
    .angle_s(angle_s), .currA_s(currA_s), .currB_s(currB_s), .currT_s(currT_s),
    .cfg_wen(cfg_wen), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready),
    .angle_out(angle_out), .currA_out(currA_out), .currB_out(currB_out), .currT_out(currT_out),
    .core_valid(core_valid), .core_ready(core_ready),
    .pid_d_wen(pid_d_wen), .pid_q_wen(pid_q_wen),
    .pid_d_addr(pid_d_addr), .pid_q_addr(pid_q_addr),
    .pid_d_data(pid_d_data), .pid_q_data(pid_q_data),
    .busy(busy), .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          trig;
    logic [DW-1:0] angle;
    logic          cwen;
    logic          csel;
    logic [DW-1:0] caddr;
    logic [DW-1:0] cdata;
    logic          rdy;
    logic          e_valid;
    logic          e_busy;
    logic          e_dwen;
    logic          e_qwen;
    logic          e_cfgrdy;
    logic [DW-1:0] e_angle;
    logic [DW-1:0] e_pdd;
    logic [DW-1:0] e_pqd;
  } vec_t;

  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic launch_to_wait();
    for (int unsigned i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rstb = 1'b0; trig_in = 1'b0; core_ready = 1'b0;
    angle_s = '0; currA_s = 19'h04000; currB_s = 19'h7C000; currT_s = 19'h12345;
    cfg_wen = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;

    //              trig angle     wen sel addr data      rdy  vld bsy dw qw crd  ang       pdd       pqd
    tbl[0]  = '{1'b1, 19'h01FFF, 1'b0, 1'b0, 19'h0, 19'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 19'h00000, 19'h0,     19'h0};
    tbl[1]  = '{1'b0, 19'h55555, 1'b0, 1'b0, 19'h0, 19'h0,     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 19'h01FFF, 19'h0,     19'h0};
    tbl[2]  = '{1'b0, 19'h55555, 1'b0, 1'b0, 19'h0, 19'h0,     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 19'h01FFF, 19'h0,     19'h0};
    tbl[3]  = '{1'b0, 19'h55555, 1'b0, 1'b0, 19'h0, 19'h0,     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 19'h01FFF, 19'h0,     19'h0};
    tbl[4]  = '{1'b0, 19'h55555, 1'b0, 1'b0, 19'h0, 19'h0,     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 19'h01FFF, 19'h0,     19'h0};
    tbl[5]  = '{1'b0, 19'h55555, 1'b0, 1'b0, 19'h0, 19'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 19'h01FFF, 19'h0,     19'h0};
    tbl[6]  = '{1'b0, 19'h55555, 1'b0, 1'b0, 19'h0, 19'h0,     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 19'h01FFF, 19'h0,     19'h0};
    tbl[7]  = '{1'b0, 19'h55555, 1'b1, 1'b0, 19'h0, 19'h01000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h01FFF, 19'h0,     19'h0};
    tbl[8]  = '{1'b0, 19'h55555, 1'b0, 1'b0, 19'h0, 19'h0,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 19'h01FFF, 19'h01000, 19'h0};
    tbl[9]  = '{1'b0, 19'h55555, 1'b0, 1'b0, 19'h0, 19'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 19'h01FFF, 19'h01000, 19'h0};
    tbl[10] = '{1'b0, 19'h55555, 1'b1, 1'b1, 19'h1, 19'h00200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h01FFF, 19'h01000, 19'h0};
    tbl[11] = '{1'b0, 19'h55555, 1'b0, 1'b0, 19'h0, 19'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 19'h01FFF, 19'h01000, 19'h00200};
    tbl[12] = '{1'b0, 19'h55555, 1'b0, 1'b0, 19'h0, 19'h0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 19'h01FFF, 19'h01000, 19'h00200};

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(core_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_angle_out", 32'(angle_out), 32'd0);
    chk("rst_overrun", 32'(overrun_cnt), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    rstb = 1'b1;
    tick();

    // Basic launch and cfg writes
    for (int i = 0; i < 13; i++) begin
      trig_in = tbl[i].trig; angle_s = tbl[i].angle;
      cfg_wen = tbl[i].cwen; cfg_sel = tbl[i].csel;
      cfg_addr = tbl[i].caddr; cfg_data = tbl[i].cdata;
      core_ready = tbl[i].rdy;
      tick();
      vec_count++;
      if (core_valid !== tbl[i].e_valid || busy !== tbl[i].e_busy ||
          pid_d_wen !== tbl[i].e_dwen || pid_q_wen !== tbl[i].e_qwen ||
          cfg_ready !== tbl[i].e_cfgrdy || angle_out !== tbl[i].e_angle ||
          pid_d_data !== tbl[i].e_pdd || pid_q_data !== tbl[i].e_pqd) begin
        miscompares++;
        $display("FAIL vec%0d: got vld=%b bsy=%b dw=%b qw=%b crd=%b ang=%h pdd=%h pqd=%h expected vld=%b bsy=%b dw=%b qw=%b crd=%b ang=%h pdd=%h pqd=%h",
                 i, core_valid, busy, pid_d_wen, pid_q_wen, cfg_ready, angle_out, pid_d_data, pid_q_data,
                 tbl[i].e_valid, tbl[i].e_busy, tbl[i].e_dwen, tbl[i].e_qwen, tbl[i].e_cfgrdy,
                 tbl[i].e_angle, tbl[i].e_pdd, tbl[i].e_pqd);
      end
    end
    chk("t1_currA_out", 32'(currA_out), 32'h04000);
    chk("t1_currB_out", 32'(currB_out), 32'h7C000);
    chk("t1_currT_out", 32'(currT_out), 32'h12345);
    chk("t2_pid_d_addr", 32'(pid_d_addr), 32'h0);
    chk("t2_pid_q_addr", 32'(pid_q_addr), 32'h1);

    // Trigger and cfg write in the same cycle: launch goes first
    trig_in = 1'b1; angle_s = 19'h00111;
    cfg_wen = 1'b1; cfg_sel = 1'b0; cfg_addr = 19'h2; cfg_data = 19'h00333;
    tick();
    trig_in = 1'b0; cfg_wen = 1'b0;
    chk("t3_cfg_ready_held", 32'(cfg_ready), 32'd0);
    tick();
    chk("t3_launch_valid", 32'(core_valid), 32'd1);
    chk("t3_launch_angle", 32'(angle_out), 32'h00111);
    for (int unsigned i = 0; i < 7; i++) begin
      tick();
      chk("t3_no_pid_wen", 32'(pid_d_wen | pid_q_wen), 32'd0);
      chk("t3_cfg_ready_low", 32'(cfg_ready), 32'd0);
    end
    chk("t3_waiting", 32'(busy), 32'd1);
    core_ready = 1'b1;
    tick();
    chk("t3_done_busy", 32'(busy), 32'd0);
    chk("t3_done_no_wen", 32'(pid_d_wen), 32'd0);
    core_ready = 1'b0;
    tick();
    chk("t3_pid_d_wen", 32'(pid_d_wen), 32'd1);
    chk("t3_pid_d_addr", 32'(pid_d_addr), 32'h2);
    chk("t3_pid_d_data", 32'(pid_d_data), 32'h00333);
    tick();
    chk("t3_pid_d_wen_drop", 32'(pid_d_wen), 32'd0);

    // Three triggers while waiting: two overruns, third snapshot launched next
    trig_in = 1'b1; angle_s = 19'h000A0;
    tick();
    trig_in = 1'b0;
    tick();
    launch_to_wait();
    chk("t4_in_wait", 32'(core_valid), 32'd0);
    for (int unsigned i = 0; i < 3; i++) begin
      trig_in = 1'b1; angle_s = 19'(19'h000A1 + i);
      tick();
    end
    trig_in = 1'b0;
    chk("t4_overrun2", 32'(overrun_cnt), 32'd2);
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    tick();
    chk("t4_relaunch_valid", 32'(core_valid), 32'd1);
    chk("t4_third_snapshot", 32'(angle_out), 32'h000A3);
    launch_to_wait();
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    tick();
    chk("t4_idle", 32'(busy), 32'd0);

    // Timeout: core_ready never rises
    trig_in = 1'b1; angle_s = 19'h00B00;
    tick();
    trig_in = 1'b0;
    tick();
    chk("t5_launch", 32'(core_valid), 32'd1);
    for (int unsigned i = 0; i < 255; i++) tick();
    chk("t5_busy_before", 32'(busy), 32'd1);
    chk("t5_err_before", 32'(timeout_err), 32'd0);
    tick();
    chk("t5_err_set", 32'(timeout_err), 32'd1);
    chk("t5_busy_clear", 32'(busy), 32'd0);
    trig_in = 1'b1; angle_s = 19'h00C00;
    tick();
    trig_in = 1'b0;
    tick();
    chk("t5_next_launch", 32'(core_valid), 32'd1);
    chk("t5_next_angle", 32'(angle_out), 32'h00C00);
    launch_to_wait();
    core_ready = 1'b1;
    tick();
    core_ready = 1'b0;
    chk("t5_complete", 32'(busy), 32'd0);
    chk("t5_err_sticky", 32'(timeout_err), 32'd1);
    tick();

    // Overrun saturation
    trig_in = 1'b1;
    for (int unsigned i = 0; i < 300; i++) tick();
    trig_in = 1'b0;
    chk("t4_saturate", 32'(overrun_cnt), 32'd255);

    // Reset mid-iteration with a held cfg write and a pending trigger
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    trig_in = 1'b1; angle_s = 19'h00D00;
    tick();
    trig_in = 1'b0;
    tick();
    launch_to_wait();
    cfg_wen = 1'b1; cfg_sel = 1'b1; cfg_addr = 19'h3; cfg_data = 19'h00077;
    trig_in = 1'b1;
    tick();
    cfg_wen = 1'b0; trig_in = 1'b0;
    chk("t6_cfg_held", 32'(cfg_ready), 32'd0);
    chk("t6_in_wait", 32'(busy), 32'd1);
    rstb = 1'b0;
    tick();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("t6_angle_out", 32'(angle_out), 32'd0);
    chk("t6_timeout", 32'(timeout_err), 32'd0);
    chk("t6_overrun", 32'(overrun_cnt), 32'd0);
    chk("t6_pid_q_addr", 32'(pid_q_addr), 32'd0);
    rstb = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_pid_write", 32'(pid_q_wen | pid_d_wen), 32'd0);
      chk("t6_stay_idle", 32'(busy | core_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
